// File: rtl/cim_shift_accumulator.sv
// Bit-plane shift-accumulator behind the CIM array: weights each plane's column psums by 2^PsumBit,
// accumulates a group (8 planes, or 3 when InFp), then holds the result. Option macro: CIM_SIGNED_MSB_EN.
module cim_shift_accumulator #(
  parameter int NUM_COL = 8,
  parameter int PSUM_W  = 6,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              InFp,
  input  logic              PsumValid,
  input  logic [2:0]        PsumBit,
  input  logic [PSUM_W-1:0] Psum   [0:NUM_COL-1],
  input  logic              OutReady,
  output logic [ACC_W-1:0]  AccOut [0:NUM_COL-1],
  output logic              OutValid,
  output logic              Busy,
  output logic              Overrun,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_infp;
  logic [2:0]       r_cnt;
  logic [ACC_W-1:0] r_acc   [0:NUM_COL-1];
  logic [ACC_W-1:0] w_term  [0:NUM_COL-1];
  logic [ACC_W-1:0] w_first [0:NUM_COL-1];
  logic [ACC_W-1:0] w_next  [0:NUM_COL-1];
  logic [2:0]       w_last;

  // w_last is the index of the final beat (Expected-1) and, when signed, the sign-weighted plane.
  always_comb begin
    w_last = r_infp ? 3'd2 : 3'd7;
    for (int c = 0; c < NUM_COL; c++) begin
      w_term[c] = {{(ACC_W-PSUM_W){1'b0}}, Psum[c]} << PsumBit;
`ifdef CIM_SIGNED_MSB_EN
      w_first[c] = (PsumBit == (InFp ? 3'd2 : 3'd7)) ? -w_term[c] : w_term[c];
      w_next[c]  = (PsumBit == w_last) ? r_acc[c] - w_term[c] : r_acc[c] + w_term[c];
`else
      w_first[c] = w_term[c];
      w_next[c]  = r_acc[c] + w_term[c];
`endif
    end
  end

  // Output handshake: AccOut transfers on a cycle where OutValid && OutReady; while OutValid is
  // high AccOut stays stable, and a beat arriving without OutReady is dropped and flags Overrun.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_infp   <= 1'b0;
      r_cnt    <= 3'd0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
      Overrun  <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        r_acc[c]  <= '0;
        AccOut[c] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (PsumValid) begin
            for (int c = 0; c < NUM_COL; c++) r_acc[c] <= w_first[c];
            r_infp  <= InFp;
            r_cnt   <= 3'd1;
            Busy    <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (PsumValid) begin
            for (int c = 0; c < NUM_COL; c++) r_acc[c] <= w_next[c];
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == w_last) begin
              for (int c = 0; c < NUM_COL; c++) AccOut[c] <= w_next[c];
              OutValid <= 1'b1;
              Busy     <= 1'b0;
              r_state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            if (PsumValid) begin
              for (int c = 0; c < NUM_COL; c++) r_acc[c] <= w_first[c];
              r_infp  <= InFp;
              r_cnt   <= 3'd1;
              Busy    <= 1'b1;
              r_state <= S_ACCUM;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (PsumValid) begin
            Overrun <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cim_shift_accumulator.sv
// Bench for cim_shift_accumulator: table of whole groups, hand-written corner sequences and
// random traffic, all checked every cycle against a group-level arithmetic model.
module tb_cim_shift_accumulator;
  localparam int NC = 8;
`ifdef CIM_SIGNED_MSB_EN
  localparam bit SIGNED_MSB = 1'b1;
`else
  localparam bit SIGNED_MSB = 1'b0;
`endif

  logic        clk;
  logic        RSTN;
  logic        InFp;
  logic        PsumValid;
  logic [2:0]  PsumBit;
  logic [5:0]  Psum   [0:NC-1];
  logic        OutReady;
  logic [15:0] AccOut [0:NC-1];
  logic        OutValid;
  logic        Busy;
  logic        Overrun;
  logic [1:0]  dbg_state;

  cim_shift_accumulator #(.NUM_COL(NC), .PSUM_W(6), .ACC_W(16)) dut (
    .clk(clk), .RSTN(RSTN), .InFp(InFp), .PsumValid(PsumValid), .PsumBit(PsumBit),
    .Psum(Psum), .OutReady(OutReady), .AccOut(AccOut), .OutValid(OutValid),
    .Busy(Busy), .Overrun(Overrun), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (group level) ----------------
  int         cur_psum [0:NC-1];
  int         m_phase;       // 0 waiting for a group, 1 collecting, 2 result pending
  int         m_beats;
  int         m_expect;
  int         m_sum   [0:NC-1];
  logic [15:0] m_out  [0:NC-1];
  logic       m_ovalid, m_busy, m_overrun;

  function automatic void model_reset();
    m_phase = 0; m_beats = 0; m_expect = 8;
    m_ovalid = 0; m_busy = 0; m_overrun = 0;
    for (int c = 0; c < NC; c++) begin m_sum[c] = 0; m_out[c] = '0; end
  endfunction

  function automatic void model_add(input int b);
    for (int c = 0; c < NC; c++) begin
      if (SIGNED_MSB && b == m_expect - 1) m_sum[c] -= cur_psum[c] * (1 << b);
      else                                 m_sum[c] += cur_psum[c] * (1 << b);
    end
    m_beats++;
  endfunction

  function automatic void model_start(input int b, input logic infp);
    m_expect = infp ? 3 : 8;
    m_beats = 0;
    for (int c = 0; c < NC; c++) m_sum[c] = 0;
    model_add(b);
    m_phase = 1;
  endfunction

  function automatic void model_clock(input logic v, input int b, input logic infp, input logic rdy);
    case (m_phase)
      0: if (v) model_start(b, infp);
      1: if (v) begin
        model_add(b);
        if (m_beats == m_expect) begin
          for (int c = 0; c < NC; c++) m_out[c] = m_sum[c][15:0];
          m_ovalid = 1;
          m_phase = 2;
        end
      end
      default: begin
        if (rdy) begin
          m_ovalid = 0;
          if (v) model_start(b, infp);
          else   m_phase = 0;
        end else if (v) begin
          m_overrun = 1;
        end
      end
    endcase
    m_busy = (m_phase == 1);
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void compare_all();
    check("OutValid", 32'(OutValid), 32'(m_ovalid));
    check("Busy", 32'(Busy), 32'(m_busy));
    check("Overrun", 32'(Overrun), 32'(m_overrun));
    for (int c = 0; c < NC; c++) check($sformatf("AccOut[%0d]", c), 32'(AccOut[c]), 32'(m_out[c]));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input int b, input logic infp, input logic rdy);
    PsumValid = v; PsumBit = 3'(b); InFp = infp; OutReady = rdy;
    for (int c = 0; c < NC; c++) Psum[c] = 6'(cur_psum[c]);
    @(posedge clk);
    model_clock(v, b, infp, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    RSTN = 1'b0; PsumValid = 1'b0; OutReady = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    RSTN = 1'b1;
  endtask

  task automatic set_psum(input int base, input int stp);
    for (int c = 0; c < NC; c++) cur_psum[c] = base + c * stp;
  endtask

  // ---------------- table of whole groups ----------------
  typedef struct {
    logic        infp;
    int          base;
    int          stp;
    logic [15:0] exp0;
    logic [15:0] exp7;
  } vec_t;
  vec_t tbl [5];

  initial begin
`ifdef CIM_SIGNED_MSB_EN
    tbl[0] = '{1'b0, 1, 1, 16'hFFFF, 16'hFFF8};
    tbl[1] = '{1'b1, 36, 0, 16'hFFDC, 16'hFFDC};
    tbl[2] = '{1'b0, 63, 0, 16'hFFC1, 16'hFFC1};
    tbl[3] = '{1'b1, 0, 5, 16'h0000, 16'hFFDD};
    tbl[4] = '{1'b0, 10, 7, 16'hFFF6, 16'hFFC5};
`else
    tbl[0] = '{1'b0, 1, 1, 16'd255, 16'd2040};
    tbl[1] = '{1'b1, 36, 0, 16'd252, 16'd252};
    tbl[2] = '{1'b0, 63, 0, 16'd16065, 16'd16065};
    tbl[3] = '{1'b1, 0, 5, 16'd0, 16'd245};
    tbl[4] = '{1'b0, 10, 7, 16'd2550, 16'd15045};
`endif
    RSTN = 1'b0; InFp = 1'b0; PsumValid = 1'b0; PsumBit = '0; OutReady = 1'b0;
    for (int c = 0; c < NC; c++) begin Psum[c] = '0; cur_psum[c] = 0; end
    model_reset();
    @(negedge clk);
    do_reset();

    // Table: back-to-back groups with OutReady high; InFp flipped after the first beat.
    for (int i = 0; i < 5; i++) begin
      int n;
      n = tbl[i].infp ? 3 : 8;
      set_psum(tbl[i].base, tbl[i].stp);
      for (int k = 0; k < n; k++) step(1'b1, k, (k == 0) ? tbl[i].infp : ~tbl[i].infp, 1'b1);
      check($sformatf("tbl%0d_valid", i), 32'(OutValid), 32'd1);
      check($sformatf("tbl%0d_acc0", i), 32'(AccOut[0]), 32'(tbl[i].exp0));
      check($sformatf("tbl%0d_acc7", i), 32'(AccOut[7]), 32'(tbl[i].exp7));
    end
    step(1'b0, 0, 1'b0, 1'b1);

    // Result held, beat in HOLD sets Overrun; then handshake + new first beat in one cycle.
    set_psum(1, 0);
    for (int k = 0; k < 8; k++) step(1'b1, k, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    check("overrun_set", 32'(Overrun), 32'd1);
    check("overrun_hold", 32'(AccOut[2]), SIGNED_MSB ? 32'hFFFF : 32'd255);
    step(1'b1, 0, 1'b0, 1'b1);
    check("restart_busy", 32'(Busy), 32'd1);
    for (int k = 1; k < 8; k++) step(1'b1, k, 1'b0, 1'b1);
    check("restart_done", 32'(OutValid), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-group, then a fresh group must carry no residue.
    set_psum(5, 3);
    for (int k = 0; k < 4; k++) step(1'b1, k, 1'b0, 1'b1);
    do_reset();
    check("rst_overrun", 32'(Overrun), 32'd0);
    set_psum(1, 0);
    for (int k = 0; k < 8; k++) step(1'b1, k, 1'b0, 1'b1);
    check("rst_fresh", 32'(AccOut[5]), SIGNED_MSB ? 32'hFFFF : 32'd255);
    step(1'b0, 0, 1'b0, 1'b1);

    // Valid every other cycle.
    set_psum(2, 1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k, 1'b0, 1'b1);
      if (k < 7) begin
        check("gap_novalid", 32'(OutValid), 32'd0);
        step(1'b0, 0, 1'b0, 1'b1);
      end
    end
    check("gap_valid", 32'(OutValid), 32'd1);
    check("gap_acc7", 32'(AccOut[7]), SIGNED_MSB ? 32'hFFF7 : 32'd2295);
    step(1'b0, 0, 1'b0, 1'b1);

    // Random traffic: gaps, arbitrary bit order/duplicates, stalls, mode flips, rare resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int c = 0; c < NC; c++) cur_psum[c] = $urandom_range(0, 63);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
